// File: rtl/neighbor_counter.sv
// Minesweeper-style adjacent-mine counter for a fixed 5x5 board.
// Latches a mine snapshot, then writes one cell count per falling edge.

module neighbor_cell #(
    parameter int ROW = 0,
    parameter int COL = 0
) (
    input  logic [24:0] snap,
    output logic [3:0]  cnt
);
    // Neighbour set is fixed per cell, so build it at elaboration time.
    function automatic logic [24:0] nbr_mask(input int r, input int c);
        logic [24:0] m;
        m = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < 5 &&
                    (c + dc) >= 0 && (c + dc) < 5)
                    m[(r + dr) * 5 + (c + dc)] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [24:0] MASK = nbr_mask(ROW, COL);

    logic [24:0] hits;
    assign hits = snap & MASK;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 25; i++)
            cnt = cnt + {3'b000, hits[i]};
    end
endmodule

module neighbor_counter (
    input  logic        clka,
    input  logic        restart,
    input  logic        place_done,
    input  logic [24:0] mines,
    input  logic [4:0]  rd_index,
    output logic        busy,
    output logic        count_done,
    output logic        counts_valid,
    output logic [3:0]  cell_count,
    output logic        rd_is_mine
);
    localparam int NUM_CELLS = 25;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state, state_nx;
    logic [24:0] snap;
    logic [4:0]  scan_idx;
    logic [3:0]  counts [NUM_CELLS];
    logic [NUM_CELLS-1:0][3:0] cell_cnt;
    logic        start, last;

    genvar g;
    generate
        for (g = 0; g < NUM_CELLS; g++) begin : g_cell
            neighbor_cell #(.ROW(g / 5), .COL(g % 5)) u_cell (
                .snap (snap),
                .cnt  (cell_cnt[g])
            );
        end
    endgenerate

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (place_done) begin
                    start    = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (scan_idx == 5'd24) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read port samples pre-edge contents, so an unscanned cell reads 0.
    always_ff @(negedge clka) begin
        if (restart) begin
            state        <= IDLE;
            snap         <= '0;
            scan_idx     <= '0;
            count_done   <= 1'b0;
            counts_valid <= 1'b0;
            cell_count   <= '0;
            rd_is_mine   <= 1'b0;
            for (int i = 0; i < NUM_CELLS; i++)
                counts[i] <= '0;
        end else begin
            state      <= state_nx;
            count_done <= last;
            if (rd_index < 5'd25) begin
                cell_count <= counts[rd_index];
                rd_is_mine <= snap[rd_index];
            end else begin
                cell_count <= '0;
                rd_is_mine <= 1'b0;
            end
            if (start) begin
                snap         <= mines;
                scan_idx     <= '0;
                counts_valid <= 1'b0;
                for (int i = 0; i < NUM_CELLS; i++)
                    counts[i] <= '0;
            end else if (state == SCAN) begin
                counts[scan_idx] <= cell_cnt[scan_idx];
                scan_idx         <= scan_idx + 5'd1;
                if (last)
                    counts_valid <= 1'b1;
            end
        end
    end

    assign busy = (state == SCAN);
endmodule

// File: tb/tb_neighbor_counter.sv
// Randomized self-checking bench for neighbor_counter against a board-level count model.

module tb_neighbor_counter;
    logic        clka = 1'b0;
    logic        restart, place_done;
    logic [24:0] mines;
    logic [4:0]  rd_index;
    logic        busy, count_done, counts_valid, rd_is_mine;
    logic [3:0]  cell_count;

    int n_cmp = 0;
    int n_err = 0;

    neighbor_counter dut (
        .clka         (clka),
        .restart      (restart),
        .place_done   (place_done),
        .mines        (mines),
        .rd_index     (rd_index),
        .busy         (busy),
        .count_done   (count_done),
        .counts_valid (counts_valid),
        .cell_count   (cell_count),
        .rd_is_mine   (rd_is_mine)
    );

    always #5 clka = ~clka;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Count mines among the in-board 8-neighbourhood of a cell.
    function automatic int ref_cnt(input logic [24:0] m, input int idx);
        int r, c, s;
        r = idx / 5;
        c = idx % 5;
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 5 &&
                    c + dc >= 0 && c + dc < 5)
                    s += int'(m[(r + dr) * 5 + c + dc]);
        return s;
    endfunction

    task automatic readback(input logic [24:0] m, input string tag);
        for (int idx = 0; idx < 32; idx++) begin
            rd_index = 5'(idx);
            @(posedge clka);
            chk($sformatf("%s_cnt[%0d]", tag, idx), int'(cell_count),
                (idx < 25) ? ref_cnt(m, idx) : 0);
            chk($sformatf("%s_mine[%0d]", tag, idx), int'(rd_is_mine),
                (idx < 25) ? int'(m[idx]) : 0);
        end
    endtask

    // Start a scan with m; optionally re-pulse place_done with noise mines mid-scan.
    task automatic run_scan(input logic [24:0] m, input int second_at, input string tag);
        int cyc;
        mines      = m;
        place_done = 1'b1;
        @(posedge clka);
        place_done = 1'b0;
        mines      = 25'($urandom);
        rd_index   = 5'd24;
        chk({tag, "_busy_start"}, int'(busy), 1);
        chk({tag, "_valid_clr"}, int'(counts_valid), 0);
        cyc = 1;
        while (cyc < 60) begin
            @(posedge clka);
            cyc++;
            if (cyc == 2) begin
                chk({tag, "_unscanned"}, int'(cell_count), 0);
                chk({tag, "_snap24"}, int'(rd_is_mine), int'(m[24]));
            end
            if (count_done) break;
            chk({tag, "_busy_scan"}, int'(busy), 1);
            place_done = (second_at > 0 && cyc == second_at);
            mines      = 25'($urandom);
        end
        place_done = 1'b0;
        chk({tag, "_done_lat"}, cyc, 26);
        chk({tag, "_busy_done"}, int'(busy), 0);
        chk({tag, "_valid_set"}, int'(counts_valid), 1);
        @(posedge clka);
        chk({tag, "_done_pulse"}, int'(count_done), 0);
        chk({tag, "_valid_hold"}, int'(counts_valid), 1);
        readback(m, tag);
    endtask

    initial begin
        logic [24:0] m;
        int seen;
        restart    = 1'b1;
        place_done = 1'b1;
        mines      = '1;
        rd_index   = 5'd0;
        repeat (2) @(posedge clka);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(count_done), 0);
        chk("rst_valid", int'(counts_valid), 0);
        chk("rst_cnt", int'(cell_count), 0);
        chk("rst_mine", int'(rd_is_mine), 0);
        restart    = 1'b0;
        place_done = 1'b0;
        @(posedge clka);
        chk("idle_busy", int'(busy), 0);

        run_scan(25'h0, 0, "zero");
        run_scan(25'h1 << 12, 0, "center");
        run_scan((25'h1 << 4) | (25'h1 << 5), 0, "wrap");
        run_scan('1, 0, "full");
        for (int t = 0; t < 4; t++)
            run_scan(25'($urandom), 0, $sformatf("rnd%0d", t));
        run_scan(25'($urandom), 5, "second");

        // Abort at the 10th scan cycle.
        m          = 25'($urandom);
        mines      = m;
        place_done = 1'b1;
        @(posedge clka);
        place_done = 1'b0;
        repeat (9) @(posedge clka);
        restart = 1'b1;
        @(posedge clka);
        restart = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(counts_valid), 0);
        seen = 0;
        repeat (30) begin
            @(posedge clka);
            seen |= int'(count_done);
        end
        chk("abort_no_done", seen, 0);
        run_scan(m, 0, "post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/neighbor_counter.md
NEIGHBOR_COUNTER -- requirements
Module: neighbor_counter

Interface
REQ-001 Parameters: none; board is fixed at 5x5 (25 cells), indexed row-major, with row = idx/5 and col = idx%5.
REQ-002 clka  in  1  single clock; all state updates occur on the falling edge of clka.
REQ-003 restart  in  1  synchronous, active-high reset, sampled on the falling edge of clka.
REQ-004 place_done  in  1  one-cycle pulse from the mine placer marking mines as final; starts a scan.
REQ-005 mines  in  25  mine map; bit i = 1 means cell i holds a mine.
REQ-006 rd_index  in  5  cell to read back.
REQ-007 busy  out  1  high while a scan is in progress.
REQ-008 count_done  out  1  one-cycle pulse when all 25 counts are written.
REQ-009 counts_valid  out  1  level; high once count_done fires, until the next scan start or restart.
REQ-010 cell_count  out  4  registered adjacent-mine count (0..8) of cell rd_index.
REQ-011 rd_is_mine  out  1  registered mine bit of cell rd_index from the latched snapshot.

Function
REQ-012 FSM states SHALL be IDLE, SCAN and DONE; the encoding is free.
REQ-013 In IDLE or DONE, place_done=1 SHALL:
- latch mines into an internal 25-bit snapshot;
- clear all 25 count entries to 0;
- set the scan index to 0;
- clear counts_valid;
- enter SCAN.
REQ-014 In SCAN, on each edge, the block SHALL write the count for cell scan_index and then increment scan_index, so there is exactly one cell per cycle, 0 through 24 in order.
REQ-015 The count for a cell SHALL be the number of snapshot mines among its up to 8 neighbours (N, S, E, W, NE, NW, SE, SW).
- Out-of-board neighbours are excluded; there is no wrap-around between columns 4 and 0 or between rows.
REQ-016 A cell's own mine bit SHALL NOT contribute to its count; mine cells still receive a count.
REQ-017 Counts SHALL use 4-bit unsigned arithmetic (maximum 8, no overflow).
REQ-018 When cell 24 is written, the FSM SHALL go to DONE on that same edge and assert count_done and counts_valid.
- Latency: with place_done sampled at edge N, cell k is written at edge N+1+k, and count_done is high for the cycle following edge N+25.
REQ-019 count_done SHALL deassert on the next edge; DONE SHALL hold counts_valid=1 until a new place_done or restart.
REQ-020 busy SHALL be 1 exactly in SCAN.
REQ-021 place_done asserted during SCAN SHALL be ignored: the scan continues on the original snapshot.
REQ-022 Changes on mines after the snapshot is latched SHALL NOT affect the counts.
REQ-023 cell_count and rd_is_mine SHALL update one edge after rd_index is sampled, in every state.
- They reflect the array contents as of that edge, so cells not yet scanned read 0.
REQ-024 rd_index values 25..31 SHALL yield cell_count=0 and rd_is_mine=0.

Reset
REQ-025 restart=1 SHALL force the following, overriding all other inputs including place_done on the same edge:
- state IDLE;
- busy, count_done and counts_valid = 0;
- cell_count = 0 and rd_is_mine = 0;
- snapshot, scan index and all count entries = 0.
REQ-026 restart asserted mid-SCAN SHALL abort the scan with no count_done pulse; a place_done after release starts a fresh scan.

Verification
REQ-027 mines=0, pulse place_done -> count_done exactly 26 edges after the pulse; all 25 reads give cell_count=0 and rd_is_mine=0.
REQ-028 mines bit 12 only -> cells 6, 7, 8, 11, 13, 16, 17, 18 read 1; all other cells read 0; rd_index=12 gives rd_is_mine=1 and cell_count=0.
REQ-029 mines bits 4 and 5 only (row-edge wrap check) -> cells 3, 8, 9 = 1; cells 0, 1, 6, 10, 11 = 1; cell 0 ≠ 2; all others 0.
REQ-030 mines all ones -> corners 0, 4, 20, 24 = 3; non-corner edge cells = 5; interior cells = 8.
REQ-031 restart pulsed at the 10th SCAN cycle -> busy=0 and counts_valid=0 the next cycle, no count_done; a subsequent place_done gives a full correct scan.
REQ-032 second place_done 5 cycles into SCAN with a different mines value -> ignored; counts match the first snapshot and count_done fires once.
